// File: rtl/eca_engine.sv
// eca_engine: elementary cellular automaton core with a generation run controller.
//
// Every cell updates from its {left, centre, right} neighbourhood through an
// 8-bit Wolfram rule. The boundary is either zero or toroidal. A start/busy/done
// handshake runs a programmed number of generations, and hold can pause the run.
//
// Optional feature: define ECA_POPCOUNT_EN to add a registered ones-count output (pop).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   load       loads data into q, aborts any run
//   data       initial cell state
//   rule       Wolfram rule, latched on accepted start
//   wrap       0 = zero boundary, 1 = toroidal, latched on accepted start
//   start      begin a run (accepted only when idle)
//   gen_count  generations to run, latched on accepted start
//   hold       freezes a run while high
//   q          current cell state
//   busy       high while running or signalling done
//   done       one-cycle completion pulse
//   generation generations applied since last load/reset (wraps)
//   pop        (ECA_POPCOUNT_EN) ones in q, one cycle behind q
module eca_engine #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [7:0]       rule,
  input  logic             wrap,
  input  logic             start,
  input  logic [CNT_W-1:0] gen_count,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] generation
`ifdef ECA_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] pop
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [7:0]       rule_r, rule_n;
  logic             wrap_r, wrap_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [CNT_W-1:0] gen_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH+1:0] ext;
  logic             busy_n, done_n;

  // Cell array padded with boundary cells: ext[i+2:i] = {L, C, R} for cell i.
  always_comb begin
    ext = {wrap_r & q[0], q, wrap_r & q[WIDTH-1]};
  end

  // One generation of the automaton under the latched rule.
  always_comb begin
    step_q = '0;
    for (int i = 0; i < WIDTH; i++) begin
      step_q[i] = rule_r[ext[i +: 3]];
    end
  end

  // Next-state and next-output logic; load overrides the run controller.
  always_comb begin
    state_n = state;
    q_n     = q;
    gen_n   = generation;
    rem_n   = rem;
    rule_n  = rule_r;
    wrap_n  = wrap_r;
    case (state)
      IDLE: begin
        if (start) begin
          if (gen_count != '0) begin
            rule_n  = rule;
            wrap_n  = wrap;
            rem_n   = gen_count;
            state_n = RUN;
          end else begin
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          q_n   = step_q;
          gen_n = generation + CNT_W'(1);
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (load) begin
      q_n     = data;
      gen_n   = '0;
      rem_n   = '0;
      state_n = IDLE;
    end
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      generation <= '0;
      rem        <= '0;
      rule_r     <= '0;
      wrap_r     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      generation <= gen_n;
      rem        <= rem_n;
      rule_r     <= rule_n;
      wrap_r     <= wrap_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

`ifdef ECA_POPCOUNT_EN
  localparam int unsigned POP_W = $clog2(WIDTH + 1);

  logic [POP_W-1:0] pop_n;

  // Ones count of the current cell state, registered one cycle behind q.
  always_comb begin
    pop_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_n = pop_n + POP_W'(q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pop <= '0;
    else       pop <= pop_n;
  end
`endif

endmodule

// File: tb/tb_eca_engine.sv
// Directed self-checking bench for eca_engine: an 8-cell and a 512-cell instance.
module tb_eca_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-cell instance
  logic        a_reset, a_load, a_wrap, a_start, a_hold;
  logic [7:0]  a_data, a_rule, a_q;
  logic [15:0] a_gen_count, a_generation;
  logic        a_busy, a_done;
`ifdef ECA_POPCOUNT_EN
  logic [3:0]  a_pop;
`endif

  // 512-cell instance
  logic         b_reset, b_load, b_wrap, b_start, b_hold;
  logic [511:0] b_data, b_q;
  logic [7:0]   b_rule;
  logic [15:0]  b_gen_count, b_generation;
  logic         b_busy, b_done;
`ifdef ECA_POPCOUNT_EN
  logic [9:0]   b_pop;
`endif

  eca_engine #(.WIDTH(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(a_reset), .load(a_load), .data(a_data), .rule(a_rule),
    .wrap(a_wrap), .start(a_start), .gen_count(a_gen_count), .hold(a_hold),
    .q(a_q), .busy(a_busy), .done(a_done), .generation(a_generation)
`ifdef ECA_POPCOUNT_EN
    , .pop(a_pop)
`endif
  );

  eca_engine #(.WIDTH(512), .CNT_W(16)) dut_b (
    .clk(clk), .reset(b_reset), .load(b_load), .data(b_data), .rule(b_rule),
    .wrap(b_wrap), .start(b_start), .gen_count(b_gen_count), .hold(b_hold),
    .q(b_q), .busy(b_busy), .done(b_done), .generation(b_generation)
`ifdef ECA_POPCOUNT_EN
    , .pop(b_pop)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_do_load(input logic [7:0] d);
    a_load = 1'b1; a_data = d;
    step();
    a_load = 1'b0;
  endtask

  task automatic a_do_start(input logic [7:0] r, input logic w, input logic [15:0] n);
    a_rule = r; a_wrap = w; a_gen_count = n; a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  // Steps until done is seen; start is dropped as soon as done appears.
  task automatic a_wait_done(output int cyc);
    cyc = 0;
    while (a_done !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    a_start = 1'b0;
  endtask

  // Runs the 512-cell instance to done, optionally holding for three edges mid-run.
  task automatic b_wait_done(input bit hold_en, output int cyc);
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 200) begin
      b_hold = hold_en && (cyc >= 4) && (cyc < 7);
      step();
      cyc++;
    end
    b_hold = 1'b0;
  endtask

  initial begin
    logic [511:0] seed, model;
    logic [7:0]   rnd;
    int           cyc;

    a_reset = 1'b1; a_load = 1'b0; a_wrap = 1'b0; a_start = 1'b0; a_hold = 1'b0;
    a_data = '0; a_rule = '0; a_gen_count = '0;
    b_reset = 1'b1; b_load = 1'b0; b_wrap = 1'b0; b_start = 1'b0; b_hold = 1'b0;
    b_data = '0; b_rule = '0; b_gen_count = '0;
    step();
    step();
    a_reset = 1'b0; b_reset = 1'b0;

    check("rst_q", a_q, 0);
    check("rst_gen", a_generation, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_b_q", b_q, 0);

    // Rule 90, zero boundary, one generation
    a_do_load(8'h01);
    check("load_q", a_q, 8'h01);
    a_do_start(8'd90, 1'b0, 16'd1);
    check("r90_accept_busy", a_busy, 1);
    check("r90_accept_q", a_q, 8'h01);
    check("r90_accept_done", a_done, 0);
    step();
    check("r90_q", a_q, 8'h02);
    check("r90_gen", a_generation, 1);
    check("r90_done", a_done, 1);
    check("r90_busy_done", a_busy, 1);
    step();
    check("r90_done_pulse", a_done, 0);
    check("r90_busy_fall", a_busy, 0);

    // Rule 90, toroidal boundary
    a_do_load(8'h01);
    a_do_start(8'd90, 1'b1, 16'd1);
    step();
    check("r90_wrap_q", a_q, 8'h82);
    step();

    // Rule 30
    a_do_load(8'h08);
    a_do_start(8'd30, 1'b0, 16'd1);
    step();
    check("r30_q", a_q, 8'h1C);
    step();
`ifdef ECA_POPCOUNT_EN
    check("r30_pop", a_pop, 3);
`endif

    // Rule 204 is the identity
    rnd = 8'($urandom);
    a_do_load(rnd);
    a_do_start(8'd204, 1'b0, 16'd5);
    a_wait_done(cyc);
    check("id_cycles", cyc, 5);
    check("id_q", a_q, rnd);
    check("id_gen", a_generation, 5);
    step();

    // gen_count = 0: immediate done, q and generation untouched
    a_do_start(8'd90, 1'b0, 16'd0);
    check("zero_done", a_done, 1);
    check("zero_busy", a_busy, 1);
    check("zero_q", a_q, rnd);
    check("zero_gen", a_generation, 5);
    step();
    check("zero_done_fall", a_done, 0);
    check("zero_busy_fall", a_busy, 0);

    // Load mid-run aborts
    a_do_load(8'h01);
    a_do_start(8'd90, 1'b0, 16'd5);
    step();
    step();
    a_do_load(8'h55);
    check("abort_q", a_q, 8'h55);
    check("abort_gen", a_generation, 0);
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    step();
    check("abort_no_done", a_done, 0);
    check("abort_q_stable", a_q, 8'h55);

    // start during RUN is ignored: 0x10 -> 0x28 -> 0x44 -> 0xAA
    a_do_load(8'h10);
    a_do_start(8'd90, 1'b0, 16'd3);
    a_start = 1'b1; a_gen_count = 16'd1; a_rule = 8'd204;
    a_wait_done(cyc);
    check("ign_cycles", cyc, 3);
    check("ign_q", a_q, 8'hAA);
    check("ign_gen", a_generation, 3);
    step();

    // Reset mid-run
    a_do_start(8'd90, 1'b0, 16'd5);
    step();
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    check("rstrun_q", a_q, 0);
    check("rstrun_gen", a_generation, 0);
    check("rstrun_busy", a_busy, 0);
    step();
    check("rstrun_busy_after", a_busy, 0);
    check("rstrun_done_after", a_done, 0);

    // 512 cells: Sierpinski row 10 from a single seed
    seed = '0;
    seed[256] = 1'b1;
    model = seed;
    for (int g = 0; g < 10; g++) model = (model << 1) ^ (model >> 1);
    b_load = 1'b1; b_data = seed;
    step();
    b_load = 1'b0;
    b_rule = 8'd90; b_wrap = 1'b0; b_gen_count = 16'd10; b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_wait_done(1'b0, cyc);
    check("sier_cycles", cyc, 10);
    check("sier_gen", b_generation, 10);
    check("sier_bit246", b_q[246], 1);
    check("sier_bit266", b_q[266], 1);
    check("sier_bit254", b_q[254], 0);
    check("sier_bit258", b_q[258], 0);
    check("sier_q", b_q, model);
    step();

    // Same run with three held cycles
    b_load = 1'b1; b_data = seed;
    step();
    b_load = 1'b0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_wait_done(1'b1, cyc);
    check("hold_cycles", cyc, 13);
    check("hold_gen", b_generation, 10);
    check("hold_q", b_q, model);
    step();
    check("hold_busy_fall", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eca_engine.md
Name: eca_engine

Overview:
- Parametrised elementary cellular automaton (ECA) engine. Generalises the fixed rule-90 array to any of the 256 Wolfram rules, a configurable array width, and selectable zero or wrap boundary.
- Adds a run controller that advances a programmed number of generations with start/busy/done handshaking, a pause input, and a generation counter.
- Sits beside the existing automaton blocks as the common compute core for pattern-generation experiments.

Parameters:
- WIDTH, 512, number of cells (>= 3).
- CNT_W, 16, width of gen_count, the remaining-generation counter and the generation output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  loads data into q; aborts any run.
- data  in  WIDTH  initial cell state.
- rule  in  8  Wolfram rule number; sampled on accepted start.
- wrap  in  1  0 = zero boundary, 1 = toroidal; sampled on accepted start.
- start  in  1  begin run; accepted only in IDLE.
- gen_count  in  CNT_W  generations to run; sampled on accepted start.
- hold  in  1  freezes a run while high.
- q  out  WIDTH  current cell state.
- busy  out  1  high in RUN or DONE.
- done  out  1  one-cycle completion pulse.
- generation  out  CNT_W  generations applied since last load/reset, modulo 2^CNT_W.

Behaviour:
- Reset, synchronous: q=0, generation=0, state=IDLE, busy=0, done=0. Latched rule, latched wrap and remaining count = 0.
- Priority on each edge: reset > load > FSM.
- Load, any state: q<=data, generation<=0, state<=IDLE. No done pulse.
- Next-state rule for cell i:
  - idx = {L,C,R} with L=q[i+1], C=q[i], R=q[i-1].
  - next[i] = rule_r[idx].
  - Out-of-range neighbours: q[WIDTH] and q[-1] read 0 when wrap_r=0. When wrap_r=1, q[WIDTH]=q[0] and q[-1]=q[WIDTH-1].
  - Rule 90 therefore reduces to next[i] = q[i+1] ^ q[i-1].
- FSM states IDLE, RUN, DONE:
  - IDLE, start=1, gen_count>0: latch rule_r, wrap_r and rem=gen_count; go to RUN. q is unchanged on this edge.
  - IDLE, start=1, gen_count=0: go to DONE. q and generation are unchanged.
  - RUN, hold=1: everything frozen.
  - RUN, hold=0: q<=next, generation<=generation+1, rem<=rem-1. When rem==1 on that edge, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE. rule and wrap changes during a run have no effect.
- Latency: start accepted at edge E0 gives N updates on edges E1..EN (with hold low). done is high in the cycle following EN; busy falls after that cycle.
- generation wraps from 2^CNT_W-1 to 0 silently.
- Reset or load mid-run: the run aborts immediately and the remaining count is discarded.

Optional Feature:
- ECA_POPCOUNT_EN defined:
  - Adds output pop, width $clog2(WIDTH+1): a registered count of ones in q, one cycle behind q.
  - pop=0 on reset. After load or an update, pop reflects the new q one edge later.
- Undefined: no pop port and no popcount logic.

Test Plan:
- WIDTH=8, load data=8'h01; start rule=90, wrap=0, gen_count=1 -> q=8'h02, generation=1, done one cycle after the update edge.
- Same stimulus with wrap=1 -> q=8'h82.
- WIDTH=8, load 8'h08; rule=30, wrap=0, gen_count=1 -> q=8'h1C. With ECA_POPCOUNT_EN, pop=3 one cycle later.
- WIDTH=512, data bit 256 only; rule=90, gen_count=10 -> done after exactly 10 non-hold update edges.
  - q matches the rule-90 Sierpinski row 10: bits 246, 266 set and 254, 258 clear; generation=10.
  - Holding hold=1 for 3 cycles mid-run delays done by exactly 3 cycles.
- Rule 204 (identity), gen_count=5 on random data -> q unchanged, generation=5.
- gen_count=0 -> done pulse with q unchanged. Load asserted mid-run -> q=data, generation=0, busy=0, no done pulse. start during RUN -> ignored. Reset mid-run -> q=0, generation=0, busy=0.
